// File: rtl/z80_bus_responder_pkg.sv
// Shared types for the Z80 bus responder: bus cycle kinds, responder FSM
// states and the wait counter width.
package z80_bus_pkg;

   localparam int WAIT_CNT_W = 4;

   typedef enum logic [2:0] {
      K_MRD  = 3'd0,
      K_MWR  = 3'd1,
      K_IORD = 3'd2,
      K_IOWR = 3'd3,
      K_INTA = 3'd4
   } bus_kind_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_HOLD,
      S_DONE
   } resp_state_t;

   // Cycles that return data to the CPU.
   function automatic logic kind_is_read(input bus_kind_t k);
      return (k == K_MRD) || (k == K_IORD) || (k == K_INTA);
   endfunction

   // Cycles that receive the extra IO wait states.
   function automatic logic kind_is_io(input bus_kind_t k);
      return (k == K_IORD) || (k == K_IOWR) || (k == K_INTA);
   endfunction

endpackage

// File: rtl/z80_bus_responder_if.sv
// CPU pin bundle plus backend handshake for the Z80 bus responder.
// slave: the responder; master: CPU/system/backend side driving it.
interface z80_bus_responder_if;

   logic [15:0] A;
   logic [7:0]  D_in;
   logic [7:0]  D_out;
   logic        D_oe;
   logic        nM1;
   logic        nMREQ;
   logic        nIORQ;
   logic        nRD;
   logic        nWR;
   logic        nRFSH;
   logic        nWAIT;
   logic        nINT;
   logic        irq_req;
   logic [7:0]  irq_vector;
   logic        be_req;
   logic [2:0]  be_kind;
   logic [15:0] be_addr;
   logic [7:0]  be_wdata;
   logic [7:0]  be_rdata;
   logic        be_ack;

   modport slave (
      input  A, D_in, nM1, nMREQ, nIORQ, nRD, nWR, nRFSH,
      input  irq_req, irq_vector, be_rdata, be_ack,
      output D_out, D_oe, nWAIT, nINT, be_req, be_kind, be_addr, be_wdata
   );

   modport master (
      output A, D_in, nM1, nMREQ, nIORQ, nRD, nWR, nRFSH,
      output irq_req, irq_vector, be_rdata, be_ack,
      input  D_out, D_oe, nWAIT, nINT, be_req, be_kind, be_addr, be_wdata
   );

endinterface

// File: rtl/z80_bus_responder_cycle_decode.sv
// Combinational decode of Z80 control pins into a bus cycle kind.
// Refresh (nMREQ with nRFSH low) yields no cycle; nMREQ and nIORQ both low
// is flagged illegal and also yields no cycle.
module z80_cycle_decode
   import z80_bus_pkg::*;
(
   input  logic      nM1,
   input  logic      nMREQ,
   input  logic      nIORQ,
   input  logic      nRD,
   input  logic      nWR,
   input  logic      nRFSH,
   output logic      valid,
   output bus_kind_t kind,
   output logic      illegal
);

   // Priority decode: memory first, then IO/INTA, INTA qualified by nM1.
   always_comb begin
      valid   = 1'b0;
      kind    = K_MRD;
      illegal = !nMREQ && !nIORQ;
      if (!illegal) begin
         if (!nMREQ && nRFSH) begin
            if (!nRD) begin
               valid = 1'b1;
               kind  = K_MRD;
            end else if (!nWR) begin
               valid = 1'b1;
               kind  = K_MWR;
            end
         end else if (!nIORQ) begin
            if (!nM1) begin
               valid = 1'b1;
               kind  = K_INTA;
            end else if (!nRD) begin
               valid = 1'b1;
               kind  = K_IORD;
            end else if (!nWR) begin
               valid = 1'b1;
               kind  = K_IOWR;
            end
         end
      end
   end

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 bus slave: decodes CPU cycles, forwards them to a backend over
// req/ack, stretches the cycle with nWAIT, drives read data back and
// generates nINT with vector return during interrupt acknowledge.
module z80_bus_responder
   import z80_bus_pkg::*;
#(
   parameter int unsigned MIN_WAIT       = 0,
   parameter int unsigned IO_EXTRA_WAIT  = 0,
   parameter logic [7:0]  VECTOR_DEFAULT = 8'hFF
) (
   input  logic CPUCLK,
   input  logic nRESET,
   z80_bus_responder_if.slave bus
);

   localparam logic [WAIT_CNT_W-1:0] MEM_WAIT = WAIT_CNT_W'(MIN_WAIT);
   localparam logic [WAIT_CNT_W-1:0] IO_WAIT  = WAIT_CNT_W'(MIN_WAIT + IO_EXTRA_WAIT);

   logic      dec_valid;
   bus_kind_t dec_kind;
   logic      dec_illegal;

   resp_state_t             state_q,    state_d;
   bus_kind_t               kind_q,     kind_d;
   logic [15:0]             addr_q,     addr_d;
   logic [7:0]              wdata_q,    wdata_d;
   logic [7:0]              rdata_q,    rdata_d;
   logic [WAIT_CNT_W-1:0]   cnt_q,      cnt_d;
   logic                    req_q,      req_d;
   logic                    ack_seen_q, ack_seen_d;
   logic                    nwait_q,    nwait_d;
   logic                    nint_q,     nint_d;
   logic                    oe_q,       oe_d;
   logic [7:0]              dout_q,     dout_d;

   logic [WAIT_CNT_W-1:0]   cnt_dec;
   logic                    ack_any;
   logic                    strobe_low;

   z80_cycle_decode u_decode (
      .nM1     (bus.nM1),
      .nMREQ   (bus.nMREQ),
      .nIORQ   (bus.nIORQ),
      .nRD     (bus.nRD),
      .nWR     (bus.nWR),
      .nRFSH   (bus.nRFSH),
      .valid   (dec_valid),
      .kind    (dec_kind),
      .illegal (dec_illegal)
   );

   // Next-state and registered-output logic for the responder FSM.
   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      ack_seen_d = ack_seen_q;
      nwait_d    = nwait_q;
      nint_d     = ~bus.irq_req;
      oe_d       = oe_q;
      dout_d     = dout_q;

      cnt_dec    = (cnt_q == '0) ? '0 : cnt_q - WAIT_CNT_W'(1);
      ack_any    = ack_seen_q || bus.be_ack;
      strobe_low = (kind_q == K_INTA) ? !bus.nIORQ : !bus.nRD;

      unique case (state_q)
         S_IDLE: begin
            if (dec_valid) begin
               state_d    = S_ACCESS;
               kind_d     = dec_kind;
               addr_d     = bus.A;
               wdata_d    = bus.D_in;
               req_d      = 1'b1;
               ack_seen_d = 1'b0;
               nwait_d    = 1'b0;
               cnt_d      = kind_is_io(dec_kind) ? IO_WAIT : MEM_WAIT;
               if (dec_kind == K_INTA) begin
                  // Vector preloaded here; backend data replaces it on ack.
                  rdata_d = bus.irq_vector;
                  nint_d  = 1'b1;
               end
            end
         end
         S_ACCESS: begin
            cnt_d = cnt_dec;
            if (kind_q == K_INTA) nint_d = 1'b1;
            if (bus.be_ack) begin
               ack_seen_d = 1'b1;
               req_d      = 1'b0;
               if (kind_is_read(kind_q)) rdata_d = bus.be_rdata;
            end
            // Ack and counter expiry on the same edge release nWAIT at once.
            if (ack_any && (cnt_dec == '0)) begin
               state_d = S_HOLD;
               nwait_d = 1'b1;
               oe_d    = kind_is_read(kind_q) && strobe_low;
               if (kind_is_read(kind_q))
                  dout_d = bus.be_ack ? bus.be_rdata : rdata_q;
            end
         end
         S_HOLD: begin
            if (kind_q == K_INTA) nint_d = 1'b1;
            oe_d = kind_is_read(kind_q) && strobe_low;
            if (bus.nMREQ && bus.nIORQ) begin
               state_d = S_DONE;
               oe_d    = 1'b0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any pending request at once.
   always_ff @(posedge CPUCLK or negedge nRESET) begin
      if (!nRESET) begin
         state_q    <= S_IDLE;
         kind_q     <= K_MRD;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= VECTOR_DEFAULT;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         ack_seen_q <= 1'b0;
         nwait_q    <= 1'b1;
         nint_q     <= 1'b1;
         oe_q       <= 1'b0;
         dout_q     <= '0;
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         ack_seen_q <= ack_seen_d;
         nwait_q    <= nwait_d;
         nint_q     <= nint_d;
         oe_q       <= oe_d;
         dout_q     <= dout_d;
      end
   end

   // Flag simultaneous memory and IO requests seen while idle.
   always_ff @(posedge CPUCLK) begin
      if (nRESET && (state_q == S_IDLE))
         assert (!dec_illegal)
         else $warning("z80_bus_responder: nMREQ and nIORQ low together, cycle ignored");
   end

   assign bus.be_req   = req_q;
   assign bus.be_kind  = kind_q;
   assign bus.be_addr  = addr_q;
   assign bus.be_wdata = wdata_q;
   assign bus.nWAIT    = nwait_q;
   assign bus.nINT     = nint_q;
   assign bus.D_oe     = oe_q;
   assign bus.D_out    = dout_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: two instances with different wait
// settings share the same CPU pins and backend ack.
module tb_z80_bus_responder;
   import z80_bus_pkg::*;

   logic CPUCLK = 1'b0;
   logic nRESET = 1'b0;
   always #5 CPUCLK = ~CPUCLK;

   z80_bus_responder_if bus0 ();
   z80_bus_responder_if bus1 ();

   assign bus1.A          = bus0.A;
   assign bus1.D_in       = bus0.D_in;
   assign bus1.nM1        = bus0.nM1;
   assign bus1.nMREQ      = bus0.nMREQ;
   assign bus1.nIORQ      = bus0.nIORQ;
   assign bus1.nRD        = bus0.nRD;
   assign bus1.nWR        = bus0.nWR;
   assign bus1.nRFSH      = bus0.nRFSH;
   assign bus1.irq_req    = bus0.irq_req;
   assign bus1.irq_vector = bus0.irq_vector;
   assign bus1.be_rdata   = bus0.be_rdata;
   assign bus1.be_ack     = bus0.be_ack;

   z80_bus_responder #(.MIN_WAIT(0), .IO_EXTRA_WAIT(2), .VECTOR_DEFAULT(8'hFF)) dut0 (
      .CPUCLK (CPUCLK),
      .nRESET (nRESET),
      .bus    (bus0.slave)
   );

   z80_bus_responder #(.MIN_WAIT(3), .IO_EXTRA_WAIT(0), .VECTOR_DEFAULT(8'hFF)) dut1 (
      .CPUCLK (CPUCLK),
      .nRESET (nRESET),
      .bus    (bus1.slave)
   );

   int passed = 0;
   int total  = 0;

   int   req_rises = 0;
   logic req_prev  = 1'b0;
   always @(negedge CPUCLK) begin
      if (bus0.be_req && !req_prev) req_rises <= req_rises + 1;
      req_prev <= bus0.be_req;
   end

   typedef struct {
      logic        req1;
      logic [2:0]  kind1;
      logic [15:0] addr1;
      logic [7:0]  wdata1;
      logic        nint1;
      int          w0;
      int          w1;
      logic        oe_any0;
      logic        oe_any1;
      logic        oe0;
      logic        oe1;
      logic [7:0]  dout0;
      logic [7:0]  dout1;
      logic        req_end;
      logic        oe_after;
      logic        nint_after1;
      logic        nint_after2;
   } obs_t;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One CPU bus cycle; be_ack pulses on the negedge numbered ack_at.
   task automatic bus_cycle(input logic [15:0] addr, input logic [7:0] din,
                            input logic m1, input logic mreq, input logic iorq,
                            input logic rd, input logic wr, input int ack_at,
                            input logic [7:0] rdata, output obs_t o);
      o.req1 = 1'b0; o.kind1 = '0; o.addr1 = '0; o.wdata1 = '0; o.nint1 = 1'b0;
      o.w0 = 0; o.w1 = 0; o.oe_any0 = 1'b0; o.oe_any1 = 1'b0;
      @(negedge CPUCLK);
      bus0.A = addr; bus0.D_in = din; bus0.nM1 = m1; bus0.nMREQ = mreq;
      bus0.nIORQ = iorq; bus0.nRD = rd; bus0.nWR = wr; bus0.nRFSH = 1'b1;
      bus0.be_rdata = rdata;
      for (int k = 1; k <= 30; k++) begin
         @(negedge CPUCLK);
         if (k == 1) begin
            o.req1 = bus0.be_req; o.kind1 = bus0.be_kind; o.addr1 = bus0.be_addr;
            o.wdata1 = bus0.be_wdata; o.nint1 = bus0.nINT;
         end
         if (!bus0.nWAIT) o.w0++;
         if (!bus1.nWAIT) o.w1++;
         if (bus0.D_oe) o.oe_any0 = 1'b1;
         if (bus1.D_oe) o.oe_any1 = 1'b1;
         bus0.be_ack = (k == ack_at);
         if (k > ack_at && bus0.nWAIT && bus1.nWAIT) break;
      end
      bus0.be_ack = 1'b0;
      o.oe0 = bus0.D_oe; o.dout0 = bus0.D_out;
      o.oe1 = bus1.D_oe; o.dout1 = bus1.D_out;
      o.req_end = bus0.be_req | bus1.be_req;
      bus0.nM1 = 1'b1; bus0.nMREQ = 1'b1; bus0.nIORQ = 1'b1;
      bus0.nRD = 1'b1; bus0.nWR = 1'b1;
      @(negedge CPUCLK);
      o.oe_after = bus0.D_oe | bus1.D_oe;
      o.nint_after1 = bus0.nINT;
      @(negedge CPUCLK);
      o.nint_after2 = bus0.nINT;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      obs_t o;
      int   rises_before;

      bus0.A = '0; bus0.D_in = '0; bus0.nM1 = 1'b1; bus0.nMREQ = 1'b1;
      bus0.nIORQ = 1'b1; bus0.nRD = 1'b1; bus0.nWR = 1'b1; bus0.nRFSH = 1'b1;
      bus0.irq_req = 1'b0; bus0.irq_vector = '0; bus0.be_rdata = '0; bus0.be_ack = 1'b0;

      // Reset state
      #12;
      chk("rst_nwait", 32'(bus0.nWAIT), 1);
      chk("rst_nint", 32'(bus0.nINT), 1);
      chk("rst_oe", 32'(bus0.D_oe), 0);
      chk("rst_dout", 32'(bus0.D_out), 32'h00);
      chk("rst_req", 32'(bus0.be_req | bus1.be_req), 0);
      chk("rst_kind", 32'(bus0.be_kind), 0);
      chk("rst_addr", 32'(bus0.be_addr), 32'h0000);
      chk("rst_wdata", 32'(bus0.be_wdata), 32'h00);
      chk("rst_nwait1", 32'(bus1.nWAIT), 1);
      @(negedge CPUCLK);
      nRESET = 1'b1;
      @(negedge CPUCLK);

      // Memory read 1234h, ack one cycle after request, data 5Ah
      bus_cycle(16'h1234, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 8'h5A, o);
      chk("mrd_req", 32'(o.req1), 1);
      chk("mrd_kind", 32'(o.kind1), 0);
      chk("mrd_addr", 32'(o.addr1), 32'h1234);
      chk("mrd_wait0", 32'(o.w0), 2);
      chk("mrd_wait1", 32'(o.w1), 3);
      chk("mrd_oe0", 32'(o.oe0), 1);
      chk("mrd_dout0", 32'(o.dout0), 32'h5A);
      chk("mrd_oe1", 32'(o.oe1), 1);
      chk("mrd_dout1", 32'(o.dout1), 32'h5A);
      chk("mrd_req_end", 32'(o.req_end), 0);
      chk("mrd_oe_after", 32'(o.oe_after), 0);

      // IO write A5h to port 0080h, immediate ack
      bus_cycle(16'h0080, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 8'h00, o);
      chk("iowr_kind", 32'(o.kind1), 3);
      chk("iowr_addr", 32'(o.addr1), 32'h0080);
      chk("iowr_wdata", 32'(o.wdata1), 32'hA5);
      chk("iowr_wait0", 32'(o.w0), 2);
      chk("iowr_wait1", 32'(o.w1), 3);
      chk("iowr_oe0", 32'(o.oe_any0), 0);
      chk("iowr_oe1", 32'(o.oe_any1), 0);

      // Refresh is ignored, then one M1 read at 0000h
      @(negedge CPUCLK);
      rises_before = req_rises;
      bus0.A = 16'h007F; bus0.nMREQ = 1'b0; bus0.nRFSH = 1'b0;
      repeat (3) @(negedge CPUCLK);
      chk("rfsh_req", 32'(bus0.be_req | bus1.be_req), 0);
      chk("rfsh_nwait", 32'(bus0.nWAIT), 1);
      bus0.nMREQ = 1'b1; bus0.nRFSH = 1'b1;
      @(negedge CPUCLK);
      chk("rfsh_rises", 32'(req_rises - rises_before), 0);
      bus_cycle(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 8'h3E, o);
      chk("m1_rises", 32'(req_rises - rises_before), 1);
      chk("m1_kind", 32'(o.kind1), 0);
      chk("m1_addr", 32'(o.addr1), 32'h0000);
      chk("m1_wait0", 32'(o.w0), 1);
      chk("m1_wait1", 32'(o.w1), 3);
      chk("m1_dout0", 32'(o.dout0), 32'h3E);

      // Interrupt request and acknowledge with vector 38h
      @(negedge CPUCLK);
      bus0.irq_req = 1'b1; bus0.irq_vector = 8'h38;
      @(negedge CPUCLK);
      chk("irq_nint0", 32'(bus0.nINT), 0);
      chk("irq_nint1", 32'(bus1.nINT), 0);
      bus_cycle(16'h0150, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 8'h38, o);
      chk("inta_kind", 32'(o.kind1), 4);
      chk("inta_nint_cycle", 32'(o.nint1), 1);
      chk("inta_wait0", 32'(o.w0), 2);
      chk("inta_wait1", 32'(o.w1), 3);
      chk("inta_oe0", 32'(o.oe0), 1);
      chk("inta_dout0", 32'(o.dout0), 32'h38);
      chk("inta_dout1", 32'(o.dout1), 32'h38);
      chk("inta_nint_done", 32'(o.nint_after1), 1);
      chk("inta_nint_again", 32'(o.nint_after2), 0);
      bus0.irq_req = 1'b0;

      // Asynchronous reset in the middle of an access
      @(negedge CPUCLK);
      bus0.A = 16'h4000; bus0.nMREQ = 1'b0; bus0.nRD = 1'b0;
      @(negedge CPUCLK);
      chk("ar_req_before", 32'(bus0.be_req), 1);
      chk("ar_nwait_before", 32'(bus0.nWAIT), 0);
      #2 nRESET = 1'b0;
      #1;
      chk("ar_req", 32'(bus0.be_req | bus1.be_req), 0);
      chk("ar_nwait", 32'(bus0.nWAIT & bus1.nWAIT), 1);
      chk("ar_oe", 32'(bus0.D_oe), 0);
      bus0.nMREQ = 1'b1; bus0.nRD = 1'b1;
      @(negedge CPUCLK);
      nRESET = 1'b1;
      @(negedge CPUCLK);
      bus0.be_rdata = 8'h77; bus0.be_ack = 1'b1;
      @(negedge CPUCLK);
      bus0.be_ack = 1'b0;
      chk("late_ack_req", 32'(bus0.be_req | bus1.be_req), 0);
      chk("late_ack_nwait", 32'(bus0.nWAIT), 1);
      chk("late_ack_dout", 32'(bus0.D_out), 32'h00);
      bus_cycle(16'h2000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 8'hC3, o);
      chk("post_rst_kind", 32'(o.kind1), 0);
      chk("post_rst_addr", 32'(o.addr1), 32'h2000);
      chk("post_rst_wait0", 32'(o.w0), 1);
      chk("post_rst_wait1", 32'(o.w1), 3);
      chk("post_rst_dout0", 32'(o.dout0), 32'hC3);

      // nMREQ and nIORQ low together: no request
      @(negedge CPUCLK);
      rises_before = req_rises;
      bus0.nMREQ = 1'b0; bus0.nIORQ = 1'b0; bus0.nRD = 1'b0;
      repeat (2) @(negedge CPUCLK);
      chk("ill_req", 32'(bus0.be_req | bus1.be_req), 0);
      chk("ill_nwait", 32'(bus0.nWAIT), 1);
      bus0.nMREQ = 1'b1; bus0.nIORQ = 1'b1; bus0.nRD = 1'b1;
      @(negedge CPUCLK);
      chk("ill_rises", 32'(req_rises - rises_before), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
